sram_nrnw_lvt: RTL and testbench

Multi-port synchronous SRAM with NUM_R read ports and NUM_W write ports, for register files and scoreboards that need more than one write per cycle.
- Built from a replicated bank array: one dual-port dpsram per (write port, read port) pair, NUM_W*NUM_R instances.
- A flop-based Live Value Table (LVT) records which write port last wrote each address.
- Adds same-cycle write-to-read forwarding, deterministic write-collision priority, per-port read-valid and a collision flag.

---
 rtl/sram_pkg.sv | 13 +
 rtl/dpsram.sv | 27 ++
 rtl/sram_lvt.sv | 58 +++++
 rtl/sram_nrnw_lvt.sv | 140 ++++++++++++++
 tb/tb_sram_nrnw_lvt.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared helpers for the LVT-based multi-port SRAM.
// Width functions and the LVT index type.
package sram_pkg;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LVT_MAX_LW = 8;

  typedef logic [LVT_MAX_LW-1:0] lvt_idx_t;

endpackage

// File: rtl/dpsram.sv
// Simple dual-port RAM bank: one write port, one registered read port.
// Read-first on same-address read/write; contents are not reset.
module dpsram #(
  parameter int W  = 32,
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_lvt.sv
// Live value table: per-address index of the last winning write port.
// Lowest-indexed port wins same-address collisions.
module sram_lvt
  import sram_pkg::*;
#(
  parameter int N     = 16,
  parameter int NUM_W = 2,
  parameter int NUM_R = 2,
  parameter int AW    = clog2_min1(N),
  parameter int LW    = clog2_min1(NUM_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_W-1:0]    wen,
  input  logic [NUM_W*AW-1:0] waddr,
  input  logic [NUM_R*AW-1:0] raddr,
  output logic [NUM_R*LW-1:0] ridx,
  output logic                collide
);

  logic [LW-1:0] lvt_q [N];
  logic [LW-1:0] lvt_d [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) lvt_q[i] <= '0;
    end else begin
      lvt_q <= lvt_d;
    end
  end

  // Descending order lets the lowest port overwrite the others.
  always_comb begin
    lvt_d = lvt_q;
    for (int w = NUM_W - 1; w >= 0; w--) begin
      if (wen[w]) lvt_d[waddr[w*AW +: AW]] = LW'(w);
    end
  end

  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NUM_W; i++) begin
      for (int j = i + 1; j < NUM_W; j++) begin
        if (wen[i] && wen[j] &&
            waddr[i*AW +: AW] == waddr[j*AW +: AW])
          collide = 1'b1;
      end
    end
  end

  always_comb begin
    ridx = '0;
    for (int g = 0; g < NUM_R; g++) begin
      ridx[g*LW +: LW] = lvt_q[raddr[g*AW +: AW]];
    end
  end

endmodule

// File: rtl/sram_nrnw_lvt.sv
// NUM_R-read / NUM_W-write SRAM from replicated banks plus an LVT.
// Adds write-to-read forwarding, read-valid and a collision flag.
module sram_nrnw_lvt
  import sram_pkg::*;
#(
  parameter int NUM_R  = 2,
  parameter int NUM_W  = 2,
  parameter int W      = 32,
  parameter int N      = 16,
  parameter int BYPASS = 1,
  localparam int AW    = clog2_min1(N),
  localparam int LW    = clog2_min1(NUM_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_R-1:0]    ren,
  input  logic [NUM_R*AW-1:0] raddr,
  output logic [NUM_R*W-1:0]  rdata,
  output logic [NUM_R-1:0]    rvalid,
  input  logic [NUM_W-1:0]    wen,
  input  logic [NUM_W*AW-1:0] waddr,
  input  logic [NUM_W*W-1:0]  wdata,
  output logic                wcollide
);

  logic [W-1:0]        bank_rd [NUM_W][NUM_R];
  logic [NUM_R*LW-1:0] ridx;
  logic                collide;

  logic [LW-1:0]    idx_q [NUM_R];
  logic [LW-1:0]    idx_d [NUM_R];
  logic [W-1:0]     fwd_q [NUM_R];
  logic [W-1:0]     fwd_d [NUM_R];
  logic [NUM_R-1:0] hit_q, hit_d;
  logic [NUM_R-1:0] seen_q, seen_d;
  logic [NUM_R-1:0] rvalid_q, rvalid_d;
  logic             wcollide_q, wcollide_d;

  sram_lvt #(
    .N     (N),
    .NUM_W (NUM_W),
    .NUM_R (NUM_R),
    .AW    (AW),
    .LW    (LW)
  ) u_lvt (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .waddr   (waddr),
    .raddr   (raddr),
    .ridx    (ridx),
    .collide (collide)
  );

  for (genvar w = 0; w < NUM_W; w++) begin : g_col
    for (genvar g = 0; g < NUM_R; g++) begin : g_row
      dpsram #(
        .W  (W),
        .N  (N),
        .AW (AW)
      ) u_bank (
        .clk   (clk),
        .we    (wen[w] & rst),
        .waddr (waddr[w*AW +: AW]),
        .wdata (wdata[w*W +: W]),
        .re    (ren[g] & rst),
        .raddr (raddr[g*AW +: AW]),
        .rdata (bank_rd[w][g])
      );
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < NUM_R; g++) begin
        idx_q[g] <= '0;
        fwd_q[g] <= '0;
      end
      hit_q      <= '0;
      seen_q     <= '0;
      rvalid_q   <= '0;
      wcollide_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      fwd_q      <= fwd_d;
      hit_q      <= hit_d;
      seen_q     <= seen_d;
      rvalid_q   <= rvalid_d;
      wcollide_q <= wcollide_d;
    end
  end

  always_comb begin
    idx_d      = idx_q;
    fwd_d      = fwd_q;
    hit_d      = hit_q;
    seen_d     = seen_q;
    rvalid_d   = ren;
    wcollide_d = collide;
    for (int g = 0; g < NUM_R; g++) begin
      if (ren[g]) begin
        seen_d[g] = 1'b1;
        idx_d[g]  = ridx[g*LW +: LW];
        hit_d[g]  = 1'b0;
        // Descending so the lowest matching port is the one kept.
        for (int w = NUM_W - 1; w >= 0; w--) begin
          if (BYPASS != 0 && wen[w] &&
              waddr[w*AW +: AW] == raddr[g*AW +: AW]) begin
            hit_d[g] = 1'b1;
            fwd_d[g] = wdata[w*W +: W];
          end
        end
      end
    end
  end

  // Zero until the first read so reset clears the visible data.
  always_comb begin
    rdata = '0;
    for (int g = 0; g < NUM_R; g++) begin
      if (seen_q[g])
        rdata[g*W +: W] = hit_q[g] ? fwd_q[g]
                                   : bank_rd[idx_q[g]][g];
    end
  end

  assign rvalid   = rvalid_q;
  assign wcollide = wcollide_q;

  for (genvar g = 0; g < NUM_R; g++) begin : g_rchk
    a_raddr: assert property (@(posedge clk) disable iff (!rst)
      ren[g] |-> int'(raddr[g*AW +: AW]) < N);
  end

  for (genvar w = 0; w < NUM_W; w++) begin : g_wchk
    a_waddr: assert property (@(posedge clk) disable iff (!rst)
      wen[w] |-> int'(waddr[w*AW +: AW]) < N);
  end

endmodule

// File: tb/tb_sram_nrnw_lvt.sv
// Bench for sram_nrnw_lvt: directed scenarios plus random traffic
// checked against an address-level memory model.
module tb_sram_nrnw_lvt;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  ren;
  logic [NR*AW-1:0] raddr;
  logic [NR*W-1:0]  rdata;
  logic [NR-1:0]  rvalid;
  logic [NW-1:0]  wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*W-1:0]  wdata;
  logic           wcollide;

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0]  cur [N];
  bit            curv [N];
  logic [W-1:0]  m0 [N];
  bit            m0v [N];
  logic [W-1:0]  exp_rd [NR];
  bit            exp_k [NR];
  logic [NR-1:0] exp_rv;
  logic          exp_wc;

  sram_nrnw_lvt #(
    .NUM_R  (NR),
    .NUM_W  (NW),
    .W      (W),
    .N      (N),
    .BYPASS (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ren      (ren),
    .raddr    (raddr),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .wcollide (wcollide)
  );

  always #5 clk = ~clk;

  function automatic int ra(int g);
    return int'(raddr[g*AW +: AW]);
  endfunction

  function automatic int wa(int w);
    return int'(waddr[w*AW +: AW]);
  endfunction

  function automatic logic [W-1:0] wd(int w);
    return wdata[w*W +: W];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wen = '0;
    ren = '0;
  endtask

  task automatic wr(int p, int a, logic [W-1:0] d);
    wen[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*W +: W] = d;
  endtask

  task automatic rd(int g, int a);
    ren[g] = 1'b1;
    raddr[g*AW +: AW] = AW'(a);
  endtask

  function automatic logic [W-1:0] rdp(int g);
    return rdata[g*W +: W];
  endfunction

  task automatic model_reset();
    for (int a = 0; a < N; a++) begin
      cur[a]  = m0[a];
      curv[a] = m0v[a];
    end
    for (int g = 0; g < NR; g++) begin
      exp_rd[g] = '0;
      exp_k[g]  = 1'b1;
    end
    exp_rv = '0;
    exp_wc = 1'b0;
  endtask

  // One clock: predict from the inputs, advance, then compare.
  task automatic cycle();
    bit hit;
    bit claimed [N];
    logic [W-1:0] d;
    for (int g = 0; g < NR; g++) begin
      if (ren[g]) begin
        hit = 1'b0;
        d = '0;
        for (int w = 0; w < NW; w++) begin
          if (!hit && wen[w] && wa(w) == ra(g)) begin
            hit = 1'b1;
            d = wd(w);
          end
        end
        if (hit) begin
          exp_rd[g] = d;
          exp_k[g]  = 1'b1;
        end else begin
          exp_rd[g] = cur[ra(g)];
          exp_k[g]  = curv[ra(g)];
        end
      end
    end
    exp_rv = ren;
    exp_wc = 1'b0;
    for (int i = 0; i < NW; i++)
      for (int j = i + 1; j < NW; j++)
        if (wen[i] && wen[j] && wa(i) == wa(j)) exp_wc = 1'b1;
    for (int a = 0; a < N; a++) claimed[a] = 1'b0;
    for (int w = 0; w < NW; w++) begin
      if (wen[w] && !claimed[wa(w)]) begin
        claimed[wa(w)] = 1'b1;
        cur[wa(w)]  = wd(w);
        curv[wa(w)] = 1'b1;
      end
    end
    if (wen[0]) begin
      m0[wa(0)]  = wd(0);
      m0v[wa(0)] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rvalid", 64'(rvalid), 64'(exp_rv));
    chk("wcollide", 64'(wcollide), 64'(exp_wc));
    for (int g = 0; g < NR; g++)
      if (exp_k[g])
        chk($sformatf("rdata%0d", g), 64'(rdp(g)), 64'(exp_rd[g]));
  endtask

  initial begin
    rst   = 1'b0;
    ren   = '0;
    raddr = '0;
    wen   = '0;
    waddr = '0;
    wdata = '0;
    for (int a = 0; a < N; a++) begin
      cur[a] = '0; curv[a] = 1'b0;
      m0[a]  = '0; m0v[a]  = 1'b0;
    end
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalid", 64'(rvalid), 64'h0);
    chk("reset_rdata", 64'(rdata), 64'h0);
    chk("reset_wcollide", 64'(wcollide), 64'h0);
    #2 rst = 1'b1;

    // single write then dual read
    idle(); wr(0, 3, 32'hA5A5_A5A5); cycle();
    idle(); rd(0, 3); rd(1, 3); cycle();
    chk("t1_rvalid", 64'(rvalid), 64'h3);
    chk("t1_rd0", 64'(rdp(0)), 64'hA5A5_A5A5);
    chk("t1_rd1", 64'(rdp(1)), 64'hA5A5_A5A5);

    // cross-port overwrite
    idle(); wr(0, 5, 32'h11); cycle();
    idle(); wr(1, 5, 32'h22); cycle();
    idle(); rd(0, 5); rd(1, 5); cycle();
    chk("t2_rd0_22", 64'(rdp(0)), 64'h22);
    chk("t2_rd1_22", 64'(rdp(1)), 64'h22);
    idle(); wr(0, 5, 32'h33); cycle();
    idle(); rd(0, 5); rd(1, 5); cycle();
    chk("t2_rd0_33", 64'(rdp(0)), 64'h33);
    chk("t2_rd1_33", 64'(rdp(1)), 64'h33);

    // write collision
    idle(); wr(0, 7, 32'h1); wr(1, 7, 32'h2); cycle();
    chk("t3_collide", 64'(wcollide), 64'h1);
    idle(); rd(0, 7); rd(1, 7); cycle();
    chk("t3_collide_clr", 64'(wcollide), 64'h0);
    chk("t3_rd0", 64'(rdp(0)), 64'h1);
    chk("t3_rd1", 64'(rdp(1)), 64'h1);

    // same-cycle forwarding
    idle(); wr(0, 2, 32'h1234); cycle();
    idle(); wr(1, 9, 32'hBEEF); rd(0, 9); rd(1, 2); cycle();
    chk("t4_fwd", 64'(rdp(0)), 64'hBEEF);
    chk("t4_nofwd", 64'(rdp(1)), 64'h1234);

    // hold with no read
    idle(); wr(0, 1, 32'h55); cycle();
    idle(); rd(0, 1); rd(1, 1); cycle();
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t5_rvalid", 64'(rvalid), 64'h0);
      chk("t5_hold0", 64'(rdp(0)), 64'h55);
      chk("t5_hold1", 64'(rdp(1)), 64'h55);
    end

    // reset mid-operation
    idle(); wr(0, 4, 32'h66); cycle();
    idle(); wr(1, 4, 32'h77); cycle();
    idle(); rd(0, 4); cycle();
    chk("t6_rd77", 64'(rdp(0)), 64'h77);
    idle(); rd(0, 4); wr(0, 6, 32'hA); wr(1, 6, 32'hB); cycle();
    #2 rst = 1'b0;
    #1;
    idle();
    model_reset();
    chk("t6_rst_rvalid", 64'(rvalid), 64'h0);
    chk("t6_rst_rdata", 64'(rdata), 64'h0);
    chk("t6_rst_wcollide", 64'(wcollide), 64'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    rd(0, 4); rd(1, 4); cycle();
    chk("t6_rd0_66", 64'(rdp(0)), 64'h66);
    chk("t6_rd1_66", 64'(rdp(1)), 64'h66);

    // random traffic on a narrow address range to provoke hits
    for (int k = 0; k < 400; k++) begin
      wen = NW'($urandom);
      ren = NR'($urandom);
      for (int w = 0; w < NW; w++) begin
        waddr[w*AW +: AW] = AW'($urandom_range(0, 7));
        wdata[w*W +: W] = $urandom;
      end
      for (int g = 0; g < NR; g++)
        raddr[g*AW +: AW] = AW'($urandom_range(0, 7));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
